// File: rtl/regfile_pkg.sv
// Shared register-file constants and types.
// Used by the read-port arbiter and its readers.
package regfile_pkg;
  localparam int NREGS      = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 64;
  localparam logic [REG_ADDR_W-1:0] XZR_ADDR = 5'd31;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;

  typedef enum logic {
    ST_EMPTY,
    ST_FULL
  } buf_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches upward from ptr, wrapping mod N.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [IW-1:0] w_pos;

  // Scan from farthest to nearest so the nearest hit wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    any   = 1'b0;
    w_pos = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_pos = IW'((int'(ptr) + k) % N);
      if (req[w_pos]) begin
        gnt        = '0;
        gnt[w_pos] = 1'b1;
        idx        = w_pos;
        any        = 1'b1;
      end
    end
  end
endmodule

// File: rtl/regfile_read_arb.sv
// Shares one register-file read port among NREQ requesters.
// Round-robin grant, one-entry registered response buffer.
module regfile_read_arb
  import regfile_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  output logic [NREQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]      rf_sel,
  input  logic [DATA_W-1:0]      rf_data,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]      rsp_data,
  input  logic [NREQ-1:0]        rsp_ready
);
  localparam int IW = $clog2(NREQ);

  buf_state_e        r_state;
  logic [IW-1:0]     r_ptr;
  logic [IW-1:0]     r_owner;
  logic [NREQ-1:0]   r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;
  logic [ADDR_W-1:0] r_sel;
  logic [NREQ-1:0]   r_hold;

  logic [NREQ-1:0]   w_gnt_oh;
  logic [IW-1:0]     w_gnt_idx;
  logic              w_any;
  logic              w_drain;
  logic              w_can_issue;
  logic              w_grant;
  logic [ADDR_W-1:0] w_addr;
  logic [IW-1:0]     w_ptr_nxt;

  rr_arbiter #(
    .N  (NREQ),
    .IW (IW)
  ) u_arb (
    .req (req_valid),
    .ptr (r_ptr),
    .gnt (w_gnt_oh),
    .idx (w_gnt_idx),
    .any (w_any)
  );

  assign w_drain     = (r_state == ST_FULL) && rsp_ready[r_owner];
  assign w_can_issue = (r_state == ST_EMPTY) || w_drain;
  assign w_grant     = reset_n && w_can_issue && w_any;
  assign w_addr      = req_addr[w_gnt_idx*ADDR_W +: ADDR_W];
  assign w_ptr_nxt   = (w_gnt_idx == IW'(NREQ - 1)) ? '0
                     : w_gnt_idx + 1'b1;

  assign req_ready = w_grant ? w_gnt_oh : '0;
  assign rf_sel    = w_grant ? w_addr : r_sel;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_EMPTY;
      r_ptr       <= '0;
      r_owner     <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_sel       <= '0;
    end else if (w_grant) begin
      r_state     <= ST_FULL;
      r_ptr       <= w_ptr_nxt;
      r_owner     <= w_gnt_idx;
      r_rsp_valid <= w_gnt_oh;
      r_sel       <= w_addr;
      // The zero register reads zero regardless of array contents.
      r_rsp_data  <= (w_addr == ADDR_W'(XZR_ADDR)) ? '0 : rf_data;
    end else if (w_drain) begin
      r_state     <= ST_EMPTY;
      r_rsp_valid <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_hold <= '0;
    else          r_hold <= req_valid & ~req_ready;
  end

  a_req_hold: assert property (
    @(posedge clk) disable iff (!reset_n)
    ((r_hold & ~req_valid) == '0)
  );
endmodule

// File: tb/tb_regfile_read_arb.sv
// Randomised scoreboard bench for regfile_read_arb.
// Reference model tracks buffer occupancy, owner and rr pointer.
module tb_regfile_read_arb;
  localparam int N  = 4;
  localparam int AW = 5;
  localparam int DW = 64;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    req_ready;
  logic [AW-1:0]   rf_sel;
  logic [DW-1:0]   rf_data;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic [N-1:0]    rsp_ready;

  logic [DW-1:0] mem [32];
  assign rf_data = mem[rf_sel];

  regfile_read_arb #(.NREQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rf_sel    (rf_sel),
    .rf_data   (rf_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    int          who;
    logic [63:0] data;
  } exp_t;
  exp_t sbq[$];

  // Reference model state
  bit           m_full;
  int           m_owner;
  int           m_ptr;
  logic [AW-1:0] m_sel;
  int           wait_cnt [N];
  logic [N-1:0] last_hs;

  always @(negedge clk) begin
    bit            can;
    int            win;
    int            j;
    logic [AW-1:0] a;
    logic [N-1:0]  hs;
    if (!reset_n) begin
      m_full  = 0;
      m_owner = 0;
      m_ptr   = 0;
      m_sel   = '0;
      last_hs = '0;
      sbq.delete();
      foreach (wait_cnt[i]) wait_cnt[i] = 0;
    end else begin
      chk("rsp_valid", 64'(rsp_valid), m_full ? 64'(1 << m_owner) : 64'd0);
      can = !m_full || rsp_ready[m_owner];
      win = -1;
      if (can)
        for (int k = 0; k < N; k++) begin
          j = (m_ptr + k) % N;
          if (win < 0 && req_valid[j]) win = j;
        end
      chk("req_ready", 64'(req_ready), (win >= 0) ? 64'(1 << win) : 64'd0);
      if (win >= 0) begin
        a = req_addr[win*AW +: AW];
        chk("rf_sel_grant", 64'(rf_sel), 64'(a));
        sbq.push_back('{who: win, data: (a == 5'd31) ? 64'd0 : mem[a]});
        m_full  = 1;
        m_owner = win;
        m_ptr   = (win + 1) % N;
        m_sel   = a;
      end else begin
        chk("rf_sel_hold", 64'(rf_sel), 64'(m_sel));
        if (m_full && rsp_ready[m_owner]) m_full = 0;
      end
      hs = req_valid & req_ready;
      if (can && req_valid != 0)
        for (int i = 0; i < N; i++) begin
          if (!req_valid[i]) wait_cnt[i] = 0;
          else if (hs[i]) begin
            chk("fair_slots_ok", 64'(wait_cnt[i] + 1 <= N), 64'd1);
            wait_cnt[i] = 0;
          end else wait_cnt[i]++;
        end
      last_hs = hs;
    end
  end

  // Monitor: pops expected responses as the DUT hands them over.
  bit          prev_held;
  logic [63:0] prev_data;

  always @(negedge clk) begin
    int   who;
    exp_t e;
    if (!reset_n || rsp_valid == 0) begin
      prev_held = 0;
    end else begin
      if (prev_held) chk("rsp_stable", rsp_data, prev_data);
      who = 0;
      for (int i = N - 1; i >= 0; i--) if (rsp_valid[i]) who = i;
      if (rsp_ready[who]) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rsp_unexpected actual=%b expected=none", rsp_valid);
        end else begin
          e = sbq.pop_front();
          chk("rsp_who", 64'(rsp_valid), 64'(1 << e.who));
          chk("rsp_data", rsp_data, e.data);
        end
        prev_held = 0;
      end else begin
        prev_held = 1;
        prev_data = rsp_data;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    req_addr[i*AW +: AW] = a;
  endtask

  task automatic drain_reqs();
    for (int k = 0; k < 16 && req_valid != 0; k++) begin
      step();
      req_valid &= ~last_hs;
    end
    chk("drain_done", 64'(req_valid), 64'd0);
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = '1;
    req_addr  = '0;
    rsp_ready = '0;
    for (int i = 0; i < 32; i++) mem[i] = {$urandom, $urandom};
    #3;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data", rsp_data, 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rf_sel", 64'(rf_sel), 64'd0);
    req_valid = '0;
    step();
    step();
    reset_n = 1'b1;
    step();

    // Single read
    mem[5] = 64'hDEAD_BEEF_0000_0005;
    set_addr(0, 5'd5);
    req_valid = 4'b0001;
    rsp_ready = '1;
    step();
    req_valid = '0;
    step();
    step();

    // Round-robin with everyone asking
    for (int i = 0; i < N; i++) set_addr(i, AW'($urandom));
    req_valid = '1;
    for (int c = 0; c < 12; c++) begin
      step();
      for (int i = 0; i < N; i++)
        if (last_hs[i]) set_addr(i, AW'($urandom));
    end
    drain_reqs();
    step();

    // Back-pressure from owner 2; non-owner ready bits are ignored
    rsp_ready = '0;
    set_addr(2, 5'd9);
    req_valid = 4'b0100;
    step();
    for (int i = 0; i < N; i++) set_addr(i, AW'($urandom));
    req_valid = '1;
    rsp_ready = 4'b1011;
    step();
    step();
    step();
    rsp_ready = 4'b0100;
    step();
    rsp_ready = '1;
    drain_reqs();
    step();

    // Zero register
    mem[31] = '1;
    set_addr(0, 5'd31);
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    step();
    step();

    // Reset while the buffer holds a response for requester 1
    rsp_ready = '0;
    set_addr(1, 5'd7);
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    step();
    #2;
    reset_n   = 1'b0;
    req_valid = '1;
    #1;
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_rsp_data", rsp_data, 64'd0);
    chk("midrst_req_ready", 64'(req_ready), 64'd0);
    chk("midrst_rf_sel", 64'(rf_sel), 64'd0);
    step();
    req_valid = '0;
    step();
    reset_n   = 1'b1;
    rsp_ready = '1;
    for (int c = 0; c < 3; c++) step();

    // Random traffic
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++)
        if (!req_valid[i] || last_hs[i]) begin
          req_valid[i] = ($urandom_range(3) != 0);
          set_addr(i, AW'($urandom));
        end
      rsp_ready = N'($urandom);
      if ($urandom_range(7) == 0) mem[$urandom_range(31)] = {$urandom, $urandom};
      step();
    end
    rsp_ready = '1;
    req_valid &= ~last_hs;
    drain_reqs();
    for (int c = 0; c < 3; c++) step();
    chk("sb_empty", 64'(sbq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
